cordic_stream_ctrl: RTL and testbench
=====================================

// Module: cordic_stream_ctrl
// PURPOSE
// Streaming front/back end for the cordic pipeline. Accepts float theta + iteration count n on a
// valid/ready input and feeds them to cordic. Tags each issued op with a LATENCY-deep valid
// delay line and captures cordic.result into an output FIFO that supports backpressure.
// cordic cannot stall, so credit-based issue guarantees the FIFO never overflows.
// PARAMETERS
// LATENCY     34  edges from the theta-sampling edge to the edge where cordic.result is valid to sample
// FIFO_DEPTH  64  result FIFO entries, power of 2, >= LATENCY for full throughput
// PORTS
// clk           in   1   clock, rising edge
// reset         in   1   asynchronous, active-low reset
// in_valid      in   1   input op valid
// in_ready      out  1   input op accepted this edge when in_valid & in_ready
// in_theta      in   32  IEEE-754 single angle (radians)
// in_n          in   5   CORDIC iteration count for this op
// cordic_theta  out  32  to cordic.theta
// cordic_n      out  5   to cordic.n
// cordic_result in   32  from cordic.result
// out_valid     out  1   FIFO head valid
// out_ready     in   1   consumer pops head when out_valid & out_ready
// out_data      out  32  FIFO head (float cosine)
// busy          out  1   ops in flight or FIFO non-empty
// BEHAVIOUR
// - Reset (reset==0, async): vld delay line cleared, inflight=0, FIFO empty, cur_n=0.
//   Resulting outputs: in_ready=1, out_valid=0, out_data=0, busy=0, cordic_n=0.
// - cordic_theta = in_theta (combinational); cordic samples it on the accept edge E0.
// - cordic_n = cur_n (register). cur_n <= in_n on each accept.
// - vld[0] <= accept; vld[i] <= vld[i-1]. capture = vld[LATENCY-1].
//   Capture pushes cordic_result at edge E0+LATENCY.
//   out_valid rises the cycle after that edge.
// - inflight (width $clog2(FIFO_DEPTH+1)) changes +1 on accept and -1 on capture.
//   Both in the same edge: no change.
// - credits = FIFO_DEPTH - inflight - fifo_count. A push and a pop on the same edge both count.
// - in_ready = (credits != 0) && (in_n == cur_n || inflight == 0).
//   cordic's n is shared by all pipeline stages, so n changes only when the pipeline is empty.
// - A new n blocks until the last old-n op is captured.
//   It is accepted on the first edge with inflight==0.
// - FIFO: first-word fall-through, out_data = head. Push and pop on the same edge, including when
//   the FIFO is full or holds one entry, keeps the count unchanged and data ordered.
//   Pointers wrap modulo FIFO_DEPTH.
// - Empty FIFO: out_data holds its last value and out_valid=0. A pop when out_valid=0 is ignored.
// - Capture while the FIFO is full cannot occur under the credit rule. Bench asserts this.
// - Results leave strictly in accept order. No op is dropped or duplicated.
// - Reset mid-operation: all tags and FIFO contents are discarded. Results still in the cordic
//   pipeline have no tag and are never captured.
// - busy = (inflight != 0) || out_valid.
// TESTING
// 1 Single op theta=0x00000000, n=31, out_ready=1
//   -> out_valid first high in the cycle after edge E0+34; out_data within 4 ulp of 0x3F800000.
//   -> busy falls the cycle after the pop.
// 2 200 ops back-to-back, random theta in [-pi/2, pi/2], n=31, out_ready=1
//   -> in_ready never drops; one result per cycle after the first.
//   -> every result matches the golden model, in order.
// 3 out_ready=0, stream n=31 -> exactly 64 ops accepted, then in_ready=0 while inflight+fifo=64.
//   -> Raising out_ready drains all 64 in order, no loss.
// 4 Op A n=31, then op B n=8 on the next cycle -> B stalls (in_ready=0) until A is captured.
//   -> B is accepted on the edge inflight reaches 0; B's result matches the n=8 model.
// 5 Reset pulsed low for 1 cycle mid-burst with 20 ops in flight
//   -> out_valid=0 and in_ready=1 immediately.
//   -> no stale result appears in the following 40 cycles.
// 6 out_ready toggling every cycle with full-rate input and the FIFO at 63/64 entries
//   -> push and pop on the same edge keep the count, never overflow, order preserved.

Source files
------------

// File: rtl/cordic_stream_ctrl.sv
// Streaming wrapper around the fixed-latency cordic pipeline: valid/ready op intake, LATENCY-deep tag line,
// and a first-word-fall-through result FIFO whose space is reserved by credits at issue time.
module cordic_stream_ctrl #(
  parameter int LATENCY    = 34,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_theta,
  input  logic [4:0]  in_n,
  output logic [31:0] cordic_theta,
  output logic [4:0]  cordic_n,
  input  logic [31:0] cordic_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] r_vld;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [31:0]        r_last;
  logic [4:0]         r_cur_n;

  logic [CW-1:0]      w_credits;
  logic               w_accept;
  logic               w_capture;
  logic               w_pop;

  // Every issued op owns a FIFO slot until popped, so a capture always finds room.
  assign w_credits    = CW'(FIFO_DEPTH) - r_inflight - r_count;
  // cordic shares one n across all stages: a different n waits for an empty pipeline.
  assign in_ready     = (w_credits != '0) && ((in_n == r_cur_n) || (r_inflight == '0));
  assign w_accept     = in_valid & in_ready;
  assign w_capture    = r_vld[LATENCY-1];
  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready;
  assign out_data     = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign cordic_theta = in_theta;
  assign cordic_n     = r_cur_n;
  assign busy         = (r_inflight != '0) || out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld      <= '0;
      r_inflight <= '0;
      r_cur_n    <= '0;
    end else begin
      r_vld      <= {r_vld[LATENCY-2:0], w_accept};
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_capture);
      if (w_accept) begin
        r_cur_n <= in_n;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_capture) - CW'(w_pop);
    end
  end

  // Storage needs no reset: r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= cordic_result;
    end
  end

endmodule

// File: tb/tb_cordic_stream_ctrl.sv
// Bench for cordic_stream_ctrl: a stand-in cordic (fixed-latency pipe, result a simple function of theta and n)
// plus an accept-order scoreboard, a table of single-op vectors and directed multi-cycle sequences.
module tb_cordic_stream_ctrl;

  localparam int LATENCY    = 34;
  localparam int FIFO_DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_theta;
  logic [4:0]  in_n;
  logic [31:0] cordic_theta;
  logic [4:0]  cordic_n;
  logic [31:0] cordic_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cordic_stream_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_theta(in_theta),
    .in_n(in_n), .cordic_theta(cordic_theta), .cordic_n(cordic_n), .cordic_result(cordic_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cordic: theta travels LATENCY edges, the pipeline's shared n is applied at the output.
  function automatic logic [31:0] cmodel(input logic [31:0] t, input logic [4:0] n);
    return t + 32'h3F80_0000 - {27'd0, n ^ 5'd31};
  endfunction

  logic [31:0] tp [LATENCY];
  always @(posedge clk) begin
    tp[0] <= cordic_theta;
    for (int i = 1; i < LATENCY; i++) tp[i] <= tp[i-1];
  end
  assign cordic_result = cmodel(tp[LATENCY-1], cordic_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard and occupancy monitor
  logic [31:0] exp_q [$];
  int acc_total = 0, pop_total = 0, drop_total = 0, max_occ = 0, occ = 0;
  int cyc = 0, last_acc_cyc = 0, prev_acc_cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      drop_total = acc_total - pop_total;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected actual=%h expected=none", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL result_order actual=%h expected=%h", out_data, e);
          end
        end
        pop_total++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cmodel(in_theta, in_n));
        acc_total++;
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc;
      end
      if (dut.r_vld[LATENCY-1] && (int'(dut.r_count) == FIFO_DEPTH)) begin
        checks++;
        errors++;
        $display("FAIL capture_while_full actual=1 expected=0");
      end
      occ = acc_total - pop_total - drop_total;
      if (occ > max_occ) max_occ = occ;
      cyc++;
    end
  end

  function automatic logic [31:0] rand_theta();
    logic [31:0] t;
    t = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 126)), 23'($urandom)};
    return t;
  endfunction

  typedef struct {
    logic [31:0] theta;
    logic [4:0]  n;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic wait_drained(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k, lat, stalls, first, last, pops, base_acc, base_pop, ovcnt;

    vecs[0] = '{32'h0000_0000, 5'd31, 32'h3F80_0000, 34};
    vecs[1] = '{32'h3F00_0000, 5'd31, 32'h7E80_0000, 34};
    vecs[2] = '{32'h1234_5678, 5'd31, 32'h51B4_5678, 34};
    vecs[3] = '{32'h0000_0000, 5'd8,  32'h3F7F_FFE9, 34};
    vecs[4] = '{32'h4049_0FDB, 5'd8,  32'h7FC9_0FC4, 34};
    vecs[5] = '{32'hBFC9_0FDB, 5'd0,  32'hFF49_0FBC, 34};

    reset = 1'b0; in_valid = 1'b0; in_theta = '0; in_n = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cordic_n", 32'(cordic_n), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Single ops from the table: latency, data, busy release, hold of last value when empty
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_theta = vecs[v].theta; in_n = vecs[v].n; out_ready = 1'b1;
      #1;
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); #1; k++; end
      chk("vec_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("vec_cordic_n", 32'(cordic_n), 32'(vecs[v].n));
      lat = 0;
      while (lat < 100) begin
        @(posedge clk); lat++; #1;
        if (out_valid) break;
      end
      chk("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
      chk("vec_data", out_data, vecs[v].exp_data);
      @(posedge clk); #1;
      chk("vec_busy_after_pop", 32'(busy), 32'd0);
      chk("vec_empty_hold", out_data, vecs[v].exp_data);
    end

    // 200 back-to-back ops, full throughput
    stalls = 0; first = -1; last = -1; pops = 0;
    for (int c = 0; c < 270; c++) begin
      @(negedge clk);
      if (c < 200) begin
        in_valid = 1'b1; in_theta = rand_theta(); in_n = 5'd31;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 200 && !in_ready) stalls++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        pops++;
      end
    end
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_pops", 32'(pops), 32'd200);
    chk("stream_span", 32'(last - first), 32'd199);
    wait_drained("stream_drain", 50);

    // Backpressure: exactly FIFO_DEPTH ops accepted, then drain in order
    base_acc = acc_total; base_pop = pop_total;
    out_ready = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_theta = rand_theta(); in_n = 5'd31;
    end
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(acc_total - base_acc), 32'(FIFO_DEPTH));
    chk("bp_occupancy", 32'(occ), 32'(FIFO_DEPTH));
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drained("bp_drain", 200);
    chk("bp_popped", 32'(pop_total - base_pop), 32'(FIFO_DEPTH));
    #1;
    chk("bp_busy", 32'(busy), 32'd0);

    // n change: B waits for A's capture, accepted on the first edge with inflight==0
    @(negedge clk);
    in_valid = 1'b1; in_theta = 32'h3E80_0000; in_n = 5'd31;
    #1;
    chk("nchg_a_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_theta = 32'h3F40_0000; in_n = 5'd8;
    #1;
    stalls = 0;
    while (!in_ready && stalls < 60) begin @(negedge clk); #1; stalls++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("nchg_stalls", 32'(stalls), 32'(LATENCY));
    chk("nchg_accept_gap", 32'(last_acc_cyc - prev_acc_cyc), 32'(LATENCY + 1));
    wait_drained("nchg_drain", 100);

    // Reset mid-burst with 20 ops in flight
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_theta = rand_theta(); in_n = 5'd8;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ovcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (out_valid) ovcnt++;
    end
    chk("rstmid_no_stale", 32'(ovcnt), 32'd0);

    // FIFO at 63/64 with full-rate input and out_ready toggling every cycle
    out_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_theta = rand_theta(); in_n = 5'd31;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("tog_full", 32'(dut.out_valid && !in_ready), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("tog_occ63", 32'(occ), 32'(FIFO_DEPTH - 1));
    base_acc = acc_total;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_theta = rand_theta(); in_n = 5'd31;
      out_ready = c[0];
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("tog_progress", 32'(acc_total - base_acc >= 90), 32'd1);
    wait_drained("tog_drain", 300);
    chk("tog_max_occ", 32'(max_occ), 32'(FIFO_DEPTH));
    #1;
    chk("tog_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
